baud_gen_frac: RTL
==================

# baud_gen_frac

Fractional-divisor baud tick generator with built-in oversampling. It produces three 1-cycle pulses from a single clock:
- an oversample tick, whose period is the divisor on average;
- a mid-bit tick, on oversample tick OVS/2 of each bit;
- a bit tick, on every OVS-th oversample tick.

It sits between the system clock and the UART TX/RX engines. Features: runtime divisor reload without glitches, and an RX resync input that re-phases the generator on a detected start-bit edge.

## Interface
- INT_WIDTH, 16, width of integer divisor part
- FRAC_WIDTH, 4, width of fractional divisor part (units of 1/2^FRAC_WIDTH clk)
- OVS, 16, oversample ticks per bit; even, >= 2
- DEF_INT, 27, integer divisor after reset
- DEF_FRAC, 2, fractional divisor after reset (27+2/16 ≈ 50 MHz / (16·115200))
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; highest priority
- en  in  1  count enable; low freezes all counters
- resync  in  1  1-cycle pulse; restarts divider and oversample phase
- dvsr_int  in  INT_WIDTH  new integer divisor; 0 treated as 1
- dvsr_frac  in  FRAC_WIDTH  new fractional divisor
- dvsr_load  in  1  1-cycle strobe; captures dvsr_int/dvsr_frac into shadow
- load_pending  out  1  shadow captured, not yet applied
- s_tick  out  1  oversample tick pulse
- h_tick  out  1  mid-bit tick pulse, coincident with an s_tick
- b_tick  out  1  bit tick pulse, coincident with an s_tick

## Operation
- Reset: cnt=0, acc=0, ext=0, os_cnt=0, cur_int=DEF_INT, cur_frac=DEF_FRAC, pending=0. Outputs s_tick/h_tick/b_tick/load_pending all 0.
- Divider: cnt increments on each en cycle. Terminal when cnt == eff_int-1+ext, where eff_int = max(cur_int,1).
  - At terminal: cnt<=0; s_tick<=1 next cycle; {ext,acc} <= acc + cur_frac, with FRAC_WIDTH+1-bit sum and carry into ext.
  - Each period therefore lasts eff_int or eff_int+1 cycles. The first period after reset/resync is eff_int, since ext=0.
- Oversample counter: os_cnt advances on each terminal, 0..OVS-1, wrapping to 0.
  - h_tick asserted with the s_tick where os_cnt was OVS/2-1.
  - b_tick asserted with the s_tick where os_cnt was OVS-1.
- Reload: dvsr_load captures inputs into shadow and sets load_pending.
  - Shadow is applied to cur_* at the next terminal, at resync, or on any cycle with en=0; acc and ext are cleared at the same time; load_pending clears.
  - load coincident with terminal: new values govern the period starting at that boundary.
  - Second load while pending: overwrites the shadow.
- Resync: cnt, acc, ext, os_cnt cleared; pending shadow applied; no tick in that cycle. Resync overrides a coincident terminal.
- en=0: counters hold, ticks 0. A pending load is applied. Resync still acts.
- Priority: reset > resync > en.

## Timing
- All outputs registered; no combinational path from input to output.
- Pulses are exactly 1 cycle wide; h_tick and b_tick never assert without s_tick.
- With en held high from the cycle after reset deassertion (cycle 1), frac=0, int=N: s_tick is high in cycles N+1, 2N+1, …, spaced exactly N cycles.
- Resync in cycle R: first s_tick in cycle R+N+1. First h_tick at the (OVS/2)-th s_tick after it, first b_tick at the OVS-th.
- Long-run s_tick spacing average = eff_int + cur_frac/2^FRAC_WIDTH cycles, with error < 1 cycle at any point.

## Structure
- Package baud_pkg:
  - default parameter values;
  - width helper giving OVS_WIDTH = clog2(OVS);
  - localparam for half index OVS/2-1.
- Sub-module baud_frac_div holds cnt/acc/ext/cur/shadow logic and emits an internal terminal strobe.
- Top baud_gen_frac adds os_cnt, output registers, and resync/en gating.

## Test plan
- Reset, int=4 frac=0, OVS=4, en=1: s_tick in cycles 5, 9, 13, 17; h_tick at cycle 9; b_tick at cycle 17.
- int=4 frac=8 (FRAC_WIDTH=4): spacings alternate 4,5,4,5; 32 ticks span exactly 144 cycles.
- dvsr_load int=6 mid-period: load_pending=1 until the boundary, then spacing 6; load on the same cycle as terminal applies at that boundary.
- resync 2 cycles before a pending s_tick: that tick suppressed; next s_tick R+N+1; os_cnt restarts, so b_tick after OVS ticks.
- en low for 10 cycles mid-period: no ticks, cnt frozen; the period resumes and completes with total enabled cycles = N. dvsr_int=0 gives s_tick every cycle.
- reset asserted mid-period with load pending: all outputs 0 next cycle; DEF_INT/DEF_FRAC restored; shadow discarded.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared defaults and sizing helpers for the fractional baud tick generator.
package baud_pkg;
   localparam int DEF_INT_WIDTH  = 16;
   localparam int DEF_FRAC_WIDTH = 4;
   localparam int DEF_OVS        = 16;
   localparam int DEF_DVSR_INT   = 27;
   localparam int DEF_DVSR_FRAC  = 2;

   localparam int DEF_HALF_IDX   = DEF_OVS / 2 - 1;

   function automatic int ovs_width(input int ovs);
      return (ovs <= 2) ? 1 : $clog2(ovs);
   endfunction

   function automatic int half_idx(input int ovs);
      return ovs / 2 - 1;
   endfunction
endpackage

// File: rtl/baud_frac_div.sv
// Fractional divider: integer counter plus fractional accumulator with a shadowed divisor.
// term is a combinational strobe on the last enabled cycle of each oversample period.
module baud_frac_div
   import baud_pkg::*;
#(
   parameter int INT_WIDTH  = DEF_INT_WIDTH,
   parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
   parameter int DEF_INT    = DEF_DVSR_INT,
   parameter int DEF_FRAC   = DEF_DVSR_FRAC
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  resync,
   input  logic [INT_WIDTH-1:0]  dvsr_int,
   input  logic [FRAC_WIDTH-1:0] dvsr_frac,
   input  logic                  dvsr_load,
   output logic                  term,
   output logic                  load_pending
);
   logic [INT_WIDTH-1:0]  cnt;
   logic [INT_WIDTH-1:0]  cur_int;
   logic [INT_WIDTH-1:0]  shadow_int;
   logic [INT_WIDTH-1:0]  eff_int;
   logic [INT_WIDTH-1:0]  limit;
   logic [INT_WIDTH-1:0]  next_int;
   logic [FRAC_WIDTH-1:0] acc;
   logic [FRAC_WIDTH-1:0] cur_frac;
   logic [FRAC_WIDTH-1:0] shadow_frac;
   logic [FRAC_WIDTH-1:0] next_frac;
   logic [FRAC_WIDTH:0]   sum;
   logic                  ext;
   logic                  pending;
   logic                  apply_now;
   logic                  apply_load;

   always_comb begin
      eff_int    = (cur_int == '0) ? INT_WIDTH'(1) : cur_int;
      // ext stretches this period by one cycle when the accumulator carried last time
      limit      = eff_int - INT_WIDTH'(1) + INT_WIDTH'(ext);
      term       = en && !resync && (cnt == limit);
      apply_now  = resync || !en || term;
      apply_load = apply_now && (dvsr_load || pending);
      // a load landing on an apply cycle bypasses the shadow
      next_int   = dvsr_load ? dvsr_int  : shadow_int;
      next_frac  = dvsr_load ? dvsr_frac : shadow_frac;
      sum        = {1'b0, acc} + {1'b0, cur_frac};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         acc         <= '0;
         ext         <= 1'b0;
         cur_int     <= INT_WIDTH'(DEF_INT);
         cur_frac    <= FRAC_WIDTH'(DEF_FRAC);
         shadow_int  <= INT_WIDTH'(DEF_INT);
         shadow_frac <= FRAC_WIDTH'(DEF_FRAC);
         pending     <= 1'b0;
      end else begin
         if (resync || term)
            cnt <= '0;
         else if (en)
            cnt <= cnt + INT_WIDTH'(1);

         if (apply_load) begin
            cur_int  <= next_int;
            cur_frac <= next_frac;
            acc      <= '0;
            ext      <= 1'b0;
         end else if (resync) begin
            acc <= '0;
            ext <= 1'b0;
         end else if (term) begin
            ext <= sum[FRAC_WIDTH];
            acc <= sum[FRAC_WIDTH-1:0];
         end

         if (apply_now)
            pending <= 1'b0;
         else if (dvsr_load)
            pending <= 1'b1;

         if (dvsr_load) begin
            shadow_int  <= dvsr_int;
            shadow_frac <= dvsr_frac;
         end
      end
   end

   assign load_pending = pending;
endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud tick generator: oversample, mid-bit and bit tick pulses, all registered.
// Ticks appear the cycle after the divider's terminal cycle; resync and en=0 suppress them.
module baud_gen_frac
   import baud_pkg::*;
#(
   parameter int INT_WIDTH  = DEF_INT_WIDTH,
   parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
   parameter int OVS        = DEF_OVS,
   parameter int DEF_INT    = DEF_DVSR_INT,
   parameter int DEF_FRAC   = DEF_DVSR_FRAC
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  resync,
   input  logic [INT_WIDTH-1:0]  dvsr_int,
   input  logic [FRAC_WIDTH-1:0] dvsr_frac,
   input  logic                  dvsr_load,
   output logic                  load_pending,
   output logic                  s_tick,
   output logic                  h_tick,
   output logic                  b_tick
);
   localparam int                   OVS_WIDTH = ovs_width(OVS);
   localparam logic [OVS_WIDTH-1:0] HALF      = OVS_WIDTH'(half_idx(OVS));
   localparam logic [OVS_WIDTH-1:0] LAST      = OVS_WIDTH'(OVS - 1);

   logic                 term;
   logic [OVS_WIDTH-1:0] os_cnt;

   baud_frac_div #(
      .INT_WIDTH  (INT_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH),
      .DEF_INT    (DEF_INT),
      .DEF_FRAC   (DEF_FRAC)
   ) u_div (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .resync       (resync),
      .dvsr_int     (dvsr_int),
      .dvsr_frac    (dvsr_frac),
      .dvsr_load    (dvsr_load),
      .term         (term),
      .load_pending (load_pending)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         os_cnt <= '0;
         s_tick <= 1'b0;
         h_tick <= 1'b0;
         b_tick <= 1'b0;
      end else begin
         // term is already masked by resync and en inside the divider
         s_tick <= term;
         h_tick <= term && (os_cnt == HALF);
         b_tick <= term && (os_cnt == LAST);
         if (resync)
            os_cnt <= '0;
         else if (term)
            os_cnt <= (os_cnt == LAST) ? '0 : os_cnt + OVS_WIDTH'(1);
      end
   end
endmodule
